// File: rtl/key_event_queue_if.sv
// Keypad event queue interface: raw key inputs plus the event handshake and decoded outputs.
interface key_event_queue_if #(
  parameter int unsigned KEY_W = 4,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             key_valid;
  logic [KEY_W-1:0] key_code;
  logic             evt_ready;
  logic             clr_overflow;
  logic             evt_valid;
  logic             dig_strobe;
  logic             ex_strobe;
  logic             op_strobe;
  logic             reset_strobe;
  logic [3:0]       dig_code;
  logic [1:0]       op_code;
  logic             overflow;
  logic [CNT_W-1:0] fifo_count;

  // Keypad/consumer side.
  modport master (
    output key_valid, key_code, evt_ready, clr_overflow,
    input  evt_valid, dig_strobe, ex_strobe, op_strobe, reset_strobe,
    input  dig_code, op_code, overflow, fifo_count
  );

  // Queue side.
  modport slave (
    input  key_valid, key_code, evt_ready, clr_overflow,
    output evt_valid, dig_strobe, ex_strobe, op_strobe, reset_strobe,
    output dig_code, op_code, overflow, fifo_count
  );
endinterface

// File: rtl/key_event_queue.sv
// Keypad front end: synchronises the raw key, detects presses, optionally auto-repeats,
// queues classified events in a FIFO and turns popped events into one-cycle strobes.
// The reset key bypasses the queue, flushing it and strobing immediately.
module key_event_queue #(
  parameter int unsigned KEY_W       = 4,
  parameter int unsigned RADIX       = 10,
  parameter int unsigned RESET_CODE  = 10,
  parameter int unsigned EX_CODE     = 11,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          REPEAT_EN   = 1'b0,
  parameter int unsigned REPEAT_DLY  = 500,
  parameter int unsigned REPEAT_PER  = 100
) (
  input logic             clk,
  input logic             rst_n,
  key_event_queue_if.slave bus
);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  function automatic logic is_digit(input logic [KEY_W-1:0] c);
    return 32'(c) < RADIX;
  endfunction

  function automatic logic is_reset(input logic [KEY_W-1:0] c);
    return 32'(c) == RESET_CODE;
  endfunction

  function automatic logic is_ex(input logic [KEY_W-1:0] c);
    return 32'(c) == EX_CODE;
  endfunction

  function automatic logic is_op(input logic [KEY_W-1:0] c);
    return 32'(c) > EX_CODE;
  endfunction

  // Synchroniser chain
  logic [SYNC_STAGES-1:0]            valid_sync_q;
  logic [SYNC_STAGES-1:0][KEY_W-1:0] code_sync_q;
  logic                              s_valid_d_q;
  logic                              s_valid;
  logic [KEY_W-1:0]                  s_code;

  // Repeat timer
  logic [REP_W-1:0] rep_cnt_q;
  logic             rep_first_q;
  logic [REP_W-1:0] rep_target;

  // FIFO
  logic [KEY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [KEY_W-1:0] head;

  // Registered outputs
  logic       dig_strobe_q, dig_strobe_d;
  logic       ex_strobe_q, ex_strobe_d;
  logic       op_strobe_q, op_strobe_d;
  logic       reset_strobe_q, reset_strobe_d;
  logic [3:0] dig_code_q, dig_code_d;
  logic [1:0] op_code_q, op_code_d;
  logic       overflow_q, overflow_d;

  logic press, held, repeatable, rep_fire, push_any, push_reset, push_evt;
  logic full, pop, do_push, drop;

  assign s_valid = valid_sync_q[SYNC_STAGES-1];
  assign s_code  = code_sync_q[SYNC_STAGES-1];
  assign head    = mem_q[rd_ptr_q];
  assign full    = (count_q == CNT_W'(DEPTH));

  // Shift key level/code through the synchroniser and keep the previous s_valid for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_sync_q <= '0;
      code_sync_q  <= '0;
      s_valid_d_q  <= 1'b0;
    end else begin
      valid_sync_q[0] <= bus.key_valid;
      code_sync_q[0]  <= bus.key_code;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        valid_sync_q[i] <= valid_sync_q[i-1];
        code_sync_q[i]  <= code_sync_q[i-1];
      end
      s_valid_d_q <= s_valid;
    end
  end

  // Press/repeat detection and classification of the pushed code
  always_comb begin
    press      = s_valid & ~s_valid_d_q;
    held       = s_valid & s_valid_d_q;
    repeatable = ~is_reset(s_code) & (is_digit(s_code) | is_op(s_code));
    rep_target = rep_first_q ? REP_W'(REPEAT_DLY) : REP_W'(REPEAT_PER);
    rep_fire   = REPEAT_EN & held & repeatable & (rep_cnt_q == rep_target);
    push_any   = press | rep_fire;
    push_reset = push_any & is_reset(s_code);
    push_evt   = push_any & ~is_reset(s_code) &
                 (is_digit(s_code) | is_ex(s_code) | is_op(s_code));
  end

  // Repeat counter: restarts at each push, saturates, clears when the key is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
    end else if (!s_valid) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
    end else if (press) begin
      rep_cnt_q   <= REP_W'(1);
      rep_first_q <= 1'b1;
    end else if (rep_fire) begin
      rep_cnt_q   <= REP_W'(1);
      rep_first_q <= 1'b0;
    end else if (rep_cnt_q != REP_W'(REP_MAX)) begin
      rep_cnt_q <= rep_cnt_q + REP_W'(1);
    end
  end

  // FIFO pointer/count next state and popped-event decode
  always_comb begin
    pop            = (count_q != '0) & bus.evt_ready;
    do_push        = push_evt & (~full | pop);
    drop           = push_evt & full & ~pop;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    dig_strobe_d   = 1'b0;
    ex_strobe_d    = 1'b0;
    op_strobe_d    = 1'b0;
    reset_strobe_d = push_reset;
    dig_code_d     = dig_code_q;
    op_code_d      = op_code_q;
    overflow_d     = drop ? 1'b1 : (bus.clr_overflow ? 1'b0 : overflow_q);
    if (push_reset) begin
      // Flush; a pop landing on the same edge is discarded
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_d     = rd_ptr_q + PTR_W'(1);
        dig_strobe_d = is_digit(head);
        ex_strobe_d  = is_ex(head);
        op_strobe_d  = is_op(head);
        if (is_digit(head)) dig_code_d = head[3:0];
        if (is_op(head))    op_code_d  = ~head[1:0];
      end
      if (do_push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && pop) count_d = count_q - CNT_W'(1);
    end
  end

  // FIFO storage; entries are only read after being written
  always_ff @(posedge clk) begin
    if (do_push && !push_reset) mem_q[wr_ptr_q] <= s_code;
  end

  // FIFO state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      dig_strobe_q   <= 1'b0;
      ex_strobe_q    <= 1'b0;
      op_strobe_q    <= 1'b0;
      reset_strobe_q <= 1'b0;
      dig_code_q     <= '0;
      op_code_q      <= '0;
      overflow_q     <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      dig_strobe_q   <= dig_strobe_d;
      ex_strobe_q    <= ex_strobe_d;
      op_strobe_q    <= op_strobe_d;
      reset_strobe_q <= reset_strobe_d;
      dig_code_q     <= dig_code_d;
      op_code_q      <= op_code_d;
      overflow_q     <= overflow_d;
    end
  end

  assign bus.evt_valid    = (count_q != '0);
  assign bus.dig_strobe   = dig_strobe_q;
  assign bus.ex_strobe    = ex_strobe_q;
  assign bus.op_strobe    = op_strobe_q;
  assign bus.reset_strobe = reset_strobe_q;
  assign bus.dig_code     = dig_code_q;
  assign bus.op_code      = op_code_q;
  assign bus.overflow     = overflow_q;
  assign bus.fifo_count   = count_q;
endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: a default instance and an auto-repeat instance.
module tb_key_event_queue;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  key_event_queue_if #(.KEY_W(4), .DEPTH(4)) bus_a ();
  key_event_queue_if #(.KEY_W(4), .DEPTH(4)) bus_b ();

  key_event_queue u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  key_event_queue #(
    .REPEAT_EN  (1'b1),
    .REPEAT_DLY (8),
    .REPEAT_PER (4)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press and release on instance A; push lands on the third tick
  task automatic press(input logic [3:0] c);
    bus_a.key_code  = c;
    bus_a.key_valid = 1'b1;
    repeat (3) tick();
    bus_a.key_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic hold_key(input logic [3:0] c, input int n);
    bus_a.key_code  = c;
    bus_a.key_valid = 1'b1;
    repeat (n) tick();
  endtask

  task automatic release_key();
    bus_a.key_valid = 1'b0;
    repeat (4) tick();
  endtask

  // Hold a key on instance B for 20 cycles and log the tick index of every push
  int push_at [8];
  int n_push;
  task automatic repeat_run(input logic [3:0] c);
    logic [2:0] prev;
    n_push          = 0;
    bus_b.evt_ready = 1'b0;
    bus_b.key_code  = c;
    bus_b.key_valid = 1'b1;
    prev            = bus_b.fifo_count;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) bus_b.key_valid = 1'b0;
      tick();
      if (bus_b.fifo_count != prev) begin
        if (n_push < 8) push_at[n_push] = i;
        n_push++;
        prev = bus_b.fifo_count;
      end
    end
  endtask

  logic [3:0] op_keys [4] = '{4'd12, 4'd13, 4'd14, 4'd15};
  logic [1:0] op_exp  [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
  int         cnt;

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    n_vec = 0;
    n_err = 0;
    bus_a.key_valid = 1'b0; bus_a.key_code = '0; bus_a.evt_ready = 1'b0;
    bus_a.clr_overflow = 1'b0;
    bus_b.key_valid = 1'b0; bus_b.key_code = '0; bus_b.evt_ready = 1'b0;
    bus_b.clr_overflow = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_evt_valid", 32'(bus_a.evt_valid), 0);
    check("rst_count", 32'(bus_a.fifo_count), 0);
    check("rst_overflow", 32'(bus_a.overflow), 0);
    check("rst_strobes", 32'({bus_a.dig_strobe, bus_a.ex_strobe, bus_a.op_strobe,
                              bus_a.reset_strobe}), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Press 7 with evt_ready=1: sync latency, single strobe, no repeat while held
    bus_a.evt_ready = 1'b1;
    bus_a.key_code  = 4'd7;
    bus_a.key_valid = 1'b1;
    tick();
    check("p7_valid_k", 32'(bus_a.evt_valid), 0);
    tick();
    check("p7_valid_k1", 32'(bus_a.evt_valid), 0);
    tick();
    check("p7_valid_k2", 32'(bus_a.evt_valid), 1);
    check("p7_count_k2", 32'(bus_a.fifo_count), 1);
    tick();
    check("p7_dig_strobe", 32'(bus_a.dig_strobe), 1);
    check("p7_dig_code", 32'(bus_a.dig_code), 7);
    check("p7_valid_after_pop", 32'(bus_a.evt_valid), 0);
    tick();
    check("p7_strobe_one_cycle", 32'(bus_a.dig_strobe), 0);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus_a.dig_strobe || bus_a.evt_valid) cnt++;
    end
    check("p7_no_repeat", 32'(cnt), 0);
    release_key();

    // Overflow with evt_ready=0 and ordered drain
    bus_a.evt_ready = 1'b0;
    for (int i = 1; i <= 5; i++) press(4'(i));
    check("ovf_count", 32'(bus_a.fifo_count), 4);
    check("ovf_flag", 32'(bus_a.overflow), 1);
    bus_a.evt_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("drain_strobe", 32'(bus_a.dig_strobe), 1);
      check("drain_code", 32'(bus_a.dig_code), 32'(i));
    end
    tick();
    check("drain_empty", 32'(bus_a.evt_valid), 0);
    check("drain_no_strobe", 32'(bus_a.dig_strobe), 0);
    check("ovf_sticky", 32'(bus_a.overflow), 1);
    bus_a.clr_overflow = 1'b1;
    tick();
    bus_a.clr_overflow = 1'b0;
    check("ovf_cleared", 32'(bus_a.overflow), 0);

    // Reset key flushes the queue and discards a simultaneous pop
    bus_a.evt_ready = 1'b0;
    press(4'd4); press(4'd5); press(4'd6);
    check("rk_queued", 32'(bus_a.fifo_count), 3);
    bus_a.key_code  = 4'd10;
    bus_a.key_valid = 1'b1;
    tick();
    tick();
    check("rk_before_push", 32'(bus_a.fifo_count), 3);
    bus_a.evt_ready = 1'b1;
    tick();
    check("rk_flush_count", 32'(bus_a.fifo_count), 0);
    check("rk_reset_strobe", 32'(bus_a.reset_strobe), 1);
    check("rk_no_dig_strobe", 32'(bus_a.dig_strobe), 0);
    check("rk_dig_code_hold", 32'(bus_a.dig_code), 4);
    bus_a.evt_ready = 1'b0;
    tick();
    check("rk_strobe_one_cycle", 32'(bus_a.reset_strobe), 0);
    check("rk_still_empty", 32'(bus_a.evt_valid), 0);
    release_key();

    // Operators then execute
    bus_a.evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hold_key(op_keys[i], 4);
      check("op_strobe", 32'(bus_a.op_strobe), 1);
      check("op_code", 32'(bus_a.op_code), 32'(op_exp[i]));
      check("op_not_dig", 32'({bus_a.dig_strobe, bus_a.ex_strobe}), 0);
      check("op_dig_code_hold", 32'(bus_a.dig_code), 4);
      release_key();
    end
    hold_key(4'd11, 4);
    check("ex_strobe", 32'(bus_a.ex_strobe), 1);
    check("ex_not_op", 32'({bus_a.dig_strobe, bus_a.op_strobe}), 0);
    check("ex_op_code_hold", 32'(bus_a.op_code), 0);
    check("ex_dig_code_hold", 32'(bus_a.dig_code), 4);
    release_key();

    // Auto-repeat on instance B: digit repeats at +8, +12, +16; execute does not
    repeat_run(4'd3);
    check("rep_push_count", 32'(n_push), 4);
    check("rep_push0", 32'(push_at[0]), 2);
    check("rep_push1", 32'(push_at[1]), 10);
    check("rep_push2", 32'(push_at[2]), 14);
    check("rep_push3", 32'(push_at[3]), 18);
    check("rep_no_overflow", 32'(bus_b.overflow), 0);
    bus_b.evt_ready = 1'b1;
    repeat (6) tick();
    check("rep_drained", 32'(bus_b.fifo_count), 0);
    check("rep_last_dig", 32'(bus_b.dig_code), 3);
    repeat_run(4'd11);
    check("rep_ex_once", 32'(n_push), 1);
    check("rep_ex_at", 32'(push_at[0]), 2);

    // Reset asserted mid-burst, then normal operation resumes
    bus_a.evt_ready = 1'b0;
    press(4'd8);
    check("mid_queued", 32'(bus_a.fifo_count), 1);
    bus_a.key_code  = 4'd2;
    bus_a.key_valid = 1'b1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_count", 32'(bus_a.fifo_count), 0);
    check("mid_rst_valid", 32'(bus_a.evt_valid), 0);
    check("mid_rst_codes", 32'({bus_a.dig_code, bus_a.op_code}), 0);
    check("mid_rst_flags", 32'({bus_a.overflow, bus_a.dig_strobe, bus_a.ex_strobe,
                                bus_a.op_strobe, bus_a.reset_strobe}), 0);
    bus_a.key_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("post_rst_count", 32'(bus_a.fifo_count), 0);
    bus_a.evt_ready = 1'b1;
    hold_key(4'd9, 4);
    check("post_rst_strobe", 32'(bus_a.dig_strobe), 1);
    check("post_rst_code", 32'(bus_a.dig_code), 9);
    release_key();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
